// File: rtl/instr_entry_queue.sv
// instr_entry_queue: front end that turns the trainer DIP switches and the
// activate push-button into an ordered stream of instructions for the CPU.
// The button is synchronized and debounced. Each debounced press captures
// the synchronized DIP word into a first-word-fall-through FIFO. The CPU
// drains the FIFO over a valid/ready handshake.
module instr_entry_queue #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DEPTH           = 4,
  parameter int INSTR_W         = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [INSTR_W-1:0]             trainer_dip,
  input  logic                           activate_button,
  output logic [INSTR_W-1:0]             instr,
  output logic                           instr_valid,
  input  logic                           instr_ready,
  output logic [$clog2(DEPTH+1)-1:0]     pending_count,
  output logic                           overflow,
  output logic [7:0]                     issue_count
);

  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int FILL_W = $clog2(DEPTH+1);

  // Synchronizer stages
  logic               btn_s1_q, btn_s1_d;
  logic               btn_s_q,  btn_s_d;
  logic [INSTR_W-1:0] dip_s1_q, dip_s1_d;
  logic [INSTR_W-1:0] dip_s_q,  dip_s_d;

  // Debouncer and press pulse
  logic               level_q, level_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic               press_q, press_d;
  logic [INSTR_W-1:0] press_data_q, press_data_d;

  // FIFO state and status
  logic [INSTR_W-1:0] mem_q [DEPTH];
  logic [INSTR_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [FILL_W-1:0]  count_q,  count_d;
  logic               overflow_q, overflow_d;
  logic [7:0]         issue_q,  issue_d;

  logic empty;
  logic full;
  logic push;
  logic pop;

  // Next-state logic for the synchronizer, debouncer, press pulse and FIFO
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path
    // through the block leaves it unassigned, which would infer a latch.
    btn_s1_d     = activate_button;
    btn_s_d      = btn_s1_q;
    dip_s1_d     = trainer_dip;
    dip_s_d      = dip_s1_q;
    level_d      = level_q;
    cnt_d        = '0;
    press_d      = 1'b0;
    press_data_d = press_data_q;

    // The level flips only after DEBOUNCE_CYCLES consecutive mismatches.
    if (btn_s_q != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES-1)) begin
        level_d = btn_s_q;
        if (btn_s_q) begin
          press_d      = 1'b1;
          press_data_d = dip_s_q;
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    empty = (count_q == '0);
    full  = (count_q == FILL_W'(DEPTH));
    pop   = !empty && instr_ready;
    // A full FIFO can still take a press when the head leaves the same cycle.
    push  = press_q && (!full || pop);

    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = press_data_q;
    end

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    case ({push, pop})
      2'b10:   count_d = count_q + FILL_W'(1);
      2'b01:   count_d = count_q - FILL_W'(1);
      default: count_d = count_q;
    endcase

    overflow_d = overflow_q || (press_q && !push);
    issue_d    = pop ? issue_q + 8'd1 : issue_q;
  end

  // Control registers with synchronous reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of block order.
    if (rst) begin
      btn_s1_q     <= 1'b0;
      btn_s_q      <= 1'b0;
      dip_s1_q     <= '0;
      dip_s_q      <= '0;
      level_q      <= 1'b1;
      cnt_q        <= '0;
      press_q      <= 1'b0;
      press_data_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      issue_q      <= '0;
    end else begin
      btn_s1_q     <= btn_s1_d;
      btn_s_q      <= btn_s_d;
      dip_s1_q     <= dip_s1_d;
      dip_s_q      <= dip_s_d;
      level_q      <= level_d;
      cnt_q        <= cnt_d;
      press_q      <= press_d;
      press_data_q <= press_data_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      issue_q      <= issue_d;
    end
  end

  // FIFO storage, written only on push
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; entries are only read while count_q marks
    // them valid, and the pointers and count are what reset clears.
    mem_q <= mem_d;
  end

  // Outputs: head word is forced to zero while the FIFO is empty
  always_comb begin
    instr_valid   = !empty;
    instr         = empty ? '0 : mem_q[rd_ptr_q];
    pending_count = count_q;
    overflow      = overflow_q;
    issue_count   = issue_q;
  end

endmodule
